dm_delay_line_ctrl: RTL and testbench
=====================================

Name: dm_delay_line_ctrl

Overview:
- Sequencer for the per-lane IOD output delay line on the DDR3 DM/DQ lanes, clocked by FAB_CLK.
- Accepts tap-adjust commands from the write-levelling/training engine: load, increment by N, or decrement by N.
- Emits correctly spaced DELAY_LINE_LOAD / DELAY_LINE_MOVE / DELAY_LINE_DIRECTION strobes and tracks the current tap.
- Aborts on DELAY_LINE_OUT_OF_RANGE or on a tap bound violation.

Parameters:
- TAP_W, 8, width of tap counter and request count.
- TAP_MAX, 127, highest legal tap index.
- LOAD_TAP, 1, tap value after a LOAD (matches the IOD TX_DELAY_VAL setting).
- MOVE_GAP, 4, settle cycles after each MOVE pulse (>=2).

Ports:
- FAB_CLK  in  1  fabric clock; all logic on the rising edge.
- ARST_N  in  1  asynchronous active-low reset.
- req_valid  in  1  command valid.
- req_ready  out  1  controller can accept a command.
- req_op  in  2  00=LOAD, 01=INC, 10=DEC, 11=reserved (treated as NOP).
- req_count  in  TAP_W  number of taps for INC/DEC.
- done  out  1  one-cycle pulse at command completion, success or error.
- err  out  1  sticky error flag; cleared by accepting the next command.
- cur_tap  out  TAP_W  tracked current tap.
- DELAY_LINE_LOAD  out  1  load strobe to the IOD.
- DELAY_LINE_MOVE  out  1  single-tap move strobe to the IOD.
- DELAY_LINE_DIRECTION  out  1  1=increment, 0=decrement.
- DELAY_LINE_OUT_OF_RANGE  in  1  IOD out-of-range flag.

Behaviour:
- Reset values: req_ready=1, done=0, err=0, cur_tap=LOAD_TAP, LOAD=0, MOVE=0, DIRECTION=0, FSM=IDLE. Reset mid-command aborts it immediately and drives no further strobes.
- Handshake: a command is accepted when req_valid & req_ready. req_ready is 1 only in IDLE. Accepting a command clears err and latches op, count and direction.

FSM states:
- IDLE: on accept, branch as follows.
  - LOAD op goes to LD.
  - INC/DEC with count=0 goes to DONE (no strobes).
  - INC/DEC with a bound violation goes to DONE with err=1, no strobes. Violations: INC with cur_tap+count>TAP_MAX; DEC with count>cur_tap. Compute at TAP_W+1 bits.
  - Otherwise goes to SETUP.
  - NOP goes to DONE.
- LD: DELAY_LINE_LOAD=1 for exactly one cycle; cur_tap<=LOAD_TAP; go to DONE.
- SETUP: DIRECTION driven for one cycle before the first MOVE and held stable until DONE; go to MV.
- MV: MOVE=1 for exactly one cycle; cur_tap+/-1; remaining count-1; go to GAP.
- GAP: MOVE=0 for MOVE_GAP cycles. During GAP, OUT_OF_RANGE=1 sets err=1 and goes to DONE (the move is still counted in cur_tap). At the end of GAP, go to MV if remaining>0, else to DONE.
- DONE: done=1 for one cycle; go to IDLE.

Latency:
- LOAD: accept edge + 2 cycles to done.
- INC/DEC of N: 1 (SETUP) + N*(1+MOVE_GAP) + 1 cycles to done.
- Back-to-back commands: next accept is possible in the cycle after done.
- MOVE is never high on two consecutive cycles; MOVE and LOAD are never high together.
- cur_tap never wraps (guaranteed by the bound check).

Optional Feature:
- Macro DM_DLY_CTRL_OOR_SYNC_EN.
- Defined: DELAY_LINE_OUT_OF_RANGE passes through a 2-flop synchronizer (reset to 0) before use. The GAP check uses the synchronized value, so MOVE_GAP must be >=3; an OOR arriving in the last GAP cycle is caught by the next GAP or by DONE sampling.
- Not defined: the flag is sampled directly, with no added latency.

Test Plan:
- Reset, then LOAD -> LOAD high for exactly 1 cycle, done 2 cycles after accept, cur_tap=1, MOVE never asserted.
- cur_tap=1, INC count=3, MOVE_GAP=4 -> DIRECTION=1 from SETUP, three 1-cycle MOVE pulses 5 cycles apart, done at cycle 17 after accept, cur_tap=4, err=0.
- cur_tap=4, DEC count=5 -> no MOVE pulses, done after 1 cycle, err=1, cur_tap=4. Next accepted command clears err.
- cur_tap=120, INC count=7 -> cur_tap=127, err=0. Then INC count=1 -> err=1, no pulse.
- INC count=10 with OUT_OF_RANGE forced high in GAP after the 2nd MOVE -> exactly 2 MOVE pulses, err=1, cur_tap=start+2, done pulse.
- ARST_N low during the 3rd GAP of an INC count=8 -> all outputs at reset values asynchronously, cur_tap=1. After release, req_ready=1 and no MOVE pulse is issued.

Source files
------------

// File: rtl/dm_delay_line_ctrl.sv
// -----------------------------------------------------------------------------
// dm_delay_line_ctrl
//
// Tap-adjust sequencer for the per-lane IOD output delay line on the DDR3
// DM/DQ lanes. It takes load / increment-by-N / decrement-by-N commands from
// the training engine and turns them into spaced single-tap strobes. It also
// tracks the current tap and aborts on a bound violation or when the IOD
// reports out-of-range.
//
// Optional build macro:
//   DM_DLY_CTRL_OOR_SYNC_EN - route DELAY_LINE_OUT_OF_RANGE through a 2-flop
//                             synchronizer before use (needs MOVE_GAP >= 3).
//                             An OOR that arrives late is also sampled in
//                             DONE. Undefined: the flag is used directly.
//
// Ports:
//   FAB_CLK                  fabric clock, rising edge
//   ARST_N                   asynchronous active-low reset
//   req_valid / req_ready    command handshake (ready only while idle)
//   req_op                   00=LOAD 01=INC 10=DEC 11=NOP
//   req_count                taps to move for INC/DEC
//   done                     one-cycle completion pulse (success or error)
//   err                      sticky error, cleared when a command is accepted
//   cur_tap                  tracked delay-line tap
//   DELAY_LINE_LOAD          load strobe to the IOD
//   DELAY_LINE_MOVE          single-tap move strobe to the IOD
//   DELAY_LINE_DIRECTION     1=increment, 0=decrement
//   DELAY_LINE_OUT_OF_RANGE  IOD out-of-range flag
// -----------------------------------------------------------------------------
module dm_delay_line_ctrl #(
  parameter int TAP_W    = 8,
  parameter int TAP_MAX  = 127,
  parameter int LOAD_TAP = 1,
  parameter int MOVE_GAP = 4
) (
  input  logic             FAB_CLK,
  input  logic             ARST_N,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [TAP_W-1:0] req_count,
  output logic             done,
  output logic             err,
  output logic [TAP_W-1:0] cur_tap,
  output logic             DELAY_LINE_LOAD,
  output logic             DELAY_LINE_MOVE,
  output logic             DELAY_LINE_DIRECTION,
  input  logic             DELAY_LINE_OUT_OF_RANGE
);

  localparam int GAP_W = $clog2(MOVE_GAP + 1);

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_INC  = 2'b01;
  localparam logic [1:0] OP_DEC  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LD    = 3'd1,
    S_SETUP = 3'd2,
    S_MV    = 3'd3,
    S_GAP   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [TAP_W-1:0] cur_tap_q, cur_tap_d;
  logic [TAP_W-1:0] rem_q, rem_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             dir_q, dir_d;
  logic             err_q, err_d;
  logic             move_q, move_d;
  logic             load_q, load_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;

  logic             oor;
  logic             accept;
  logic [TAP_W:0]   inc_sum;
  logic             inc_viol;
  logic             dec_viol;

`ifdef DM_DLY_CTRL_OOR_SYNC_EN
  logic oor_s1_q, oor_s2_q;
  // Set once the command has issued strobes, so a late OOR seen in DONE is
  // only charged to a command that actually moved the line.
  logic moved_q, moved_d;

  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      oor_s1_q <= 1'b0;
      oor_s2_q <= 1'b0;
    end else begin
      oor_s1_q <= DELAY_LINE_OUT_OF_RANGE;
      oor_s2_q <= oor_s1_q;
    end
  end

  assign oor = oor_s2_q;
`else
  assign oor = DELAY_LINE_OUT_OF_RANGE;
`endif

  assign accept = req_valid & ready_q;

  // Bound checks are done one bit wider so the sum cannot wrap.
  assign inc_sum  = {1'b0, cur_tap_q} + {1'b0, req_count};
  assign inc_viol = inc_sum > (TAP_W + 1)'(TAP_MAX);
  assign dec_viol = req_count > cur_tap_q;

  always_comb begin
    state_d   = state_q;
    cur_tap_d = cur_tap_q;
    rem_d     = rem_q;
    gap_d     = gap_q;
    dir_d     = dir_q;
    err_d     = err_q;
`ifdef DM_DLY_CTRL_OOR_SYNC_EN
    moved_d   = moved_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          err_d = 1'b0;
          rem_d = req_count;
`ifdef DM_DLY_CTRL_OOR_SYNC_EN
          moved_d = 1'b0;
`endif
          case (req_op)
            OP_LOAD: state_d = S_LD;
            OP_INC, OP_DEC: begin
              if (req_count == '0) begin
                state_d = S_DONE;
              end else if ((req_op == OP_INC && inc_viol) ||
                           (req_op == OP_DEC && dec_viol)) begin
                state_d = S_DONE;
                err_d   = 1'b1;
              end else begin
                state_d = S_SETUP;
                dir_d   = (req_op == OP_INC);
`ifdef DM_DLY_CTRL_OOR_SYNC_EN
                moved_d = 1'b1;
`endif
              end
            end
            default: state_d = S_DONE;
          endcase
        end
      end

      S_LD: begin
        cur_tap_d = TAP_W'(LOAD_TAP);
        state_d   = S_DONE;
      end

      // DIRECTION is already valid here, one cycle ahead of the first MOVE.
      S_SETUP: state_d = S_MV;

      S_MV: begin
        cur_tap_d = dir_q ? (cur_tap_q + TAP_W'(1)) : (cur_tap_q - TAP_W'(1));
        rem_d     = rem_q - TAP_W'(1);
        gap_d     = GAP_W'(MOVE_GAP - 1);
        state_d   = S_GAP;
      end

      S_GAP: begin
        // The move that triggered OOR has already been counted in cur_tap.
        if (oor) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (gap_q == '0) begin
          state_d = (rem_q != '0) ? S_MV : S_DONE;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end

      S_DONE: begin
`ifdef DM_DLY_CTRL_OOR_SYNC_EN
        if (oor && moved_q) err_d = 1'b1;
`endif
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // Strobes are registered versions of the next state, so each is high
    // for exactly the cycles the FSM spends in the matching state.
    load_d  = (state_d == S_LD);
    move_d  = (state_d == S_MV);
    done_d  = (state_d == S_DONE);
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      state_q   <= S_IDLE;
      cur_tap_q <= TAP_W'(LOAD_TAP);
      rem_q     <= '0;
      gap_q     <= '0;
      dir_q     <= 1'b0;
      err_q     <= 1'b0;
      move_q    <= 1'b0;
      load_q    <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
`ifdef DM_DLY_CTRL_OOR_SYNC_EN
      moved_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cur_tap_q <= cur_tap_d;
      rem_q     <= rem_d;
      gap_q     <= gap_d;
      dir_q     <= dir_d;
      err_q     <= err_d;
      move_q    <= move_d;
      load_q    <= load_d;
      done_q    <= done_d;
      ready_q   <= ready_d;
`ifdef DM_DLY_CTRL_OOR_SYNC_EN
      moved_q   <= moved_d;
`endif
    end
  end

  assign req_ready            = ready_q;
  assign done                 = done_q;
  assign err                  = err_q;
  assign cur_tap              = cur_tap_q;
  assign DELAY_LINE_LOAD      = load_q;
  assign DELAY_LINE_MOVE      = move_q;
  assign DELAY_LINE_DIRECTION = dir_q;

endmodule

// File: tb/tb_dm_delay_line_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for dm_delay_line_ctrl: a directed vector table, randomized
// commands against a behavioural model, and an asynchronous reset issued in
// the middle of a command.
// -----------------------------------------------------------------------------
module tb_dm_delay_line_ctrl;

  localparam int TAP_W    = 8;
  localparam int TAP_MAX  = 127;
  localparam int LOAD_TAP = 1;
  localparam int GAP      = 4;
  localparam int BUDGET   = 1000;

  logic             clk;
  logic             arst_n;
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [TAP_W-1:0] req_count;
  logic             done;
  logic             err;
  logic [TAP_W-1:0] cur_tap;
  logic             dl_load;
  logic             dl_move;
  logic             dl_dir;
  logic             dl_oor;

  dm_delay_line_ctrl #(
    .TAP_W   (TAP_W),
    .TAP_MAX (TAP_MAX),
    .LOAD_TAP(LOAD_TAP),
    .MOVE_GAP(GAP)
  ) dut (
    .FAB_CLK                (clk),
    .ARST_N                 (arst_n),
    .req_valid              (req_valid),
    .req_ready              (req_ready),
    .req_op                 (req_op),
    .req_count              (req_count),
    .done                   (done),
    .err                    (err),
    .cur_tap                (cur_tap),
    .DELAY_LINE_LOAD        (dl_load),
    .DELAY_LINE_MOVE        (dl_move),
    .DELAY_LINE_DIRECTION   (dl_dir),
    .DELAY_LINE_OUT_OF_RANGE(dl_oor)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errs++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0] op;
    int         cnt;
    int         oor_k;   // force OOR high after this MOVE pulse (0 = never)
    int         e_err;
    int         e_tap;
    int         e_moves;
    int         e_loads;
    int         e_lat;   // cycles from the accept edge to the done pulse
  } vec_t;

  vec_t tbl[17];

  // Behavioural reference: outcome of one command from the rules alone.
  task automatic model(input int tap, input int op, input int cnt, input int k,
                       output int e_err, output int e_tap, output int e_moves,
                       output int e_loads, output int e_lat);
    e_err = 0; e_tap = tap; e_moves = 0; e_loads = 0; e_lat = 1;
    if (op == 0) begin
      e_tap = LOAD_TAP; e_loads = 1; e_lat = 2;
    end else if (op == 1 || op == 2) begin
      if (cnt == 0) begin
        e_lat = 1;
      end else if ((op == 1 && tap + cnt > TAP_MAX) || (op == 2 && cnt > tap)) begin
        e_err = 1; e_lat = 1;
      end else if (k >= 1 && k <= cnt) begin
        e_err   = 1;
        e_moves = k;
        e_tap   = (op == 1) ? tap + k : tap - k;
        // setup, k-1 full move periods, the k-th move, one gap cycle, done
        e_lat   = 1 + (k - 1) * (1 + GAP) + 1 + 1 + 1;
      end else begin
        e_moves = cnt;
        e_tap   = (op == 1) ? tap + cnt : tap - cnt;
        e_lat   = 1 + cnt * (1 + GAP) + 1;
      end
    end
  endtask

  // Issue one command and observe it until done; all waits are bounded.
  task automatic run_cmd(input logic [1:0] op, input int cnt, input int oor_k,
                         input int e_err, input int e_tap, input int e_moves,
                         input int e_loads, input int e_lat, input string tag);
    int moves, loads, lat, dir_setup, bad, w, c, err_at_done, tap_at_done;
    int e_dir;
    logic prev_move;
    moves = 0; loads = 0; lat = -1; dir_setup = 0; bad = 0; w = 0;
    err_at_done = -1; tap_at_done = -1; prev_move = 1'b0;
    e_dir = (op == 2'b01) ? 1 : 0;
    while (!req_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_ready"}, int'(req_ready), 1);
    req_valid = 1'b1;
    req_op    = op;
    req_count = cnt[TAP_W-1:0];
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    c = 1;
    while (1) begin
      if (dl_move) moves++;
      if (dl_load) loads++;
      if (dl_move && dl_load) bad = 1;
      if (dl_move && prev_move) bad = 1;
      if (dl_move && int'(dl_dir) != e_dir) bad = 1;
      prev_move = dl_move;
      if (c == 1) dir_setup = int'(dl_dir);
      if (dl_move && moves == oor_k) dl_oor = 1'b1;
      if (done) begin
        if (req_ready) bad = 1;
        lat         = c;
        err_at_done = int'(err);
        tap_at_done = int'(cur_tap);
        break;
      end
      if (c >= BUDGET) break;
      @(negedge clk);
      c++;
    end
    dl_oor = 1'b0;
    check({tag, "_lat"},   lat,         e_lat);
    check({tag, "_err"},   err_at_done, e_err);
    check({tag, "_tap"},   tap_at_done, e_tap);
    check({tag, "_moves"}, moves,       e_moves);
    check({tag, "_loads"}, loads,       e_loads);
    check({tag, "_proto"}, bad,         0);
    if (e_moves > 0) check({tag, "_dir"}, dir_setup, e_dir);
  endtask

  function automatic int out_vec();
    return int'({req_ready, done, err, cur_tap, dl_load, dl_move, dl_dir});
  endfunction

  // ready=1, done=0, err=0, cur_tap=LOAD_TAP, LOAD=MOVE=DIRECTION=0
  localparam int RST_VEC = (1 << 13) | (LOAD_TAP << 3);

  initial begin
    int mtap, op, cnt, k, e_err, e_tap, e_moves, e_loads, e_lat, mv, c;

    tbl[0]  = '{2'b00,   0, 0, 0,   1,   0, 1,   2};
    tbl[1]  = '{2'b01,   3, 0, 0,   4,   3, 0,  17};
    tbl[2]  = '{2'b10,   5, 0, 1,   4,   0, 0,   1};
    tbl[3]  = '{2'b11,   0, 0, 0,   4,   0, 0,   1};
    tbl[4]  = '{2'b10,   3, 0, 0,   1,   3, 0,  17};
    tbl[5]  = '{2'b01, 119, 0, 0, 120, 119, 0, 597};
    tbl[6]  = '{2'b01,   7, 0, 0, 127,   7, 0,  37};
    tbl[7]  = '{2'b01,   1, 0, 1, 127,   0, 0,   1};
    tbl[8]  = '{2'b10,   0, 0, 0, 127,   0, 0,   1};
    tbl[9]  = '{2'b00,   0, 0, 0,   1,   0, 1,   2};
    tbl[10] = '{2'b01,  10, 2, 1,   3,   2, 0,   9};
    tbl[11] = '{2'b10,   2, 0, 0,   1,   2, 0,  12};
    tbl[12] = '{2'b10,   1, 0, 0,   0,   1, 0,   7};
    tbl[13] = '{2'b10,   1, 0, 1,   0,   0, 0,   1};
    tbl[14] = '{2'b01, 127, 0, 0, 127, 127, 0, 637};
    tbl[15] = '{2'b10, 128, 0, 1, 127,   0, 0,   1};
    tbl[16] = '{2'b01, 255, 0, 1, 127,   0, 0,   1};

    arst_n    = 1'b0;
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_count = '0;
    dl_oor    = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", out_vec(), RST_VEC);
    arst_n = 1'b1;
    @(negedge clk);
    check("post_reset_state", out_vec(), RST_VEC);

    for (int i = 0; i < 17; i++) begin
      run_cmd(tbl[i].op, tbl[i].cnt, tbl[i].oor_k, tbl[i].e_err, tbl[i].e_tap,
              tbl[i].e_moves, tbl[i].e_loads, tbl[i].e_lat, $sformatf("vec%0d", i));
    end

    mtap = 127;
    for (int i = 0; i < 40; i++) begin
      op  = int'($urandom_range(0, 3));
      cnt = int'($urandom_range(0, 20));
      k   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, cnt + 1)) : 0;
      model(mtap, op, cnt, k, e_err, e_tap, e_moves, e_loads, e_lat);
      run_cmd(op[1:0], cnt, k, e_err, e_tap, e_moves, e_loads, e_lat,
              $sformatf("rnd%0d", i));
      mtap = e_tap;
    end

    // Reset during the third gap of an INC 8 started from the load tap.
    run_cmd(2'b00, 0, 0, 0, 1, 0, 1, 2, "rst_load");
    c = 0;
    while (!req_ready && c < 50) begin
      @(negedge clk);
      c++;
    end
    req_valid = 1'b1;
    req_op    = 2'b01;
    req_count = 8'd8;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    mv = 0;
    c  = 0;
    while (c < 200) begin
      if (dl_move) mv++;
      if (mv >= 3) break;
      @(negedge clk);
      c++;
    end
    check("rst_moves_before", mv, 3);
    @(negedge clk);
    @(negedge clk);
    check("rst_tap_before", int'(cur_tap), 4);
    #2 arst_n = 1'b0;
    #1 check("rst_async_state", out_vec(), RST_VEC);
    @(negedge clk);
    @(negedge clk);
    arst_n = 1'b1;
    mv = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (dl_move || dl_load || done) mv++;
    end
    check("rst_no_strobes_after", mv, 0);
    check("rst_ready_after", int'(req_ready), 1);
    check("rst_tap_after", int'(cur_tap), LOAD_TAP);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
